// File: rtl/aes_trigger_ctrl_if.sv
// Handshake bundle between the register block / AES core and the trigger
// controller. The controller connects through the slave modport.
interface aes_trigger_ctrl_if #(
  parameter int pDELAY_WIDTH = 16,
  parameter int pCNT_WIDTH   = 16
);
  logic                    start_i;
  logic [pDELAY_WIDTH-1:0] delay_i;
  logic                    clear_err_i;
  logic                    core_busy_i;
  logic                    core_load_o;
  logic                    trigger_o;
  logic                    busy_o;
  logic                    done_o;
  logic [pCNT_WIDTH-1:0]   cycles_o;
  logic                    timeout_o;
  logic                    overrun_o;

  modport master (
    output start_i, delay_i, clear_err_i, core_busy_i,
    input  core_load_o, trigger_o, busy_o, done_o, cycles_o, timeout_o, overrun_o
  );

  modport slave (
    input  start_i, delay_i, clear_err_i, core_busy_i,
    output core_load_o, trigger_o, busy_o, done_o, cycles_o, timeout_o, overrun_o
  );
endinterface

// File: rtl/aes_trigger_ctrl.sv
// Sequences one AES operation: optional delay, load pulse, busy handshake,
// busy-cycle measurement, scope trigger window and sticky error flags.
module aes_trigger_ctrl #(
  parameter int pDELAY_WIDTH = 16,
  parameter int pCNT_WIDTH   = 16,
  parameter int pWAIT_MAX    = 8,
  parameter int pRUN_MAX     = 4096
) (
  input  logic             clk,
  input  logic             reset,
  aes_trigger_ctrl_if.slave bus
);
  localparam int cWAIT_W = $clog2(pWAIT_MAX + 1);
  localparam logic [cWAIT_W-1:0]    cWAIT_LAST = cWAIT_W'(pWAIT_MAX - 1);
  localparam logic [pCNT_WIDTH-1:0] cRUN_MAX   = pCNT_WIDTH'(pRUN_MAX);

  typedef enum logic [2:0] {IDLE, DELAY, LOAD, WAIT_BUSY, RUN, DONE} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [pDELAY_WIDTH-1:0] r_delay;
  logic [cWAIT_W-1:0]      r_wait;
  logic [pCNT_WIDTH-1:0]   r_cnt;
  logic [pCNT_WIDTH-1:0]   w_cnt_inc;
  logic [pCNT_WIDTH-1:0]   r_cycles;
  logic                    r_trigger;
  logic                    r_timeout;
  logic                    r_overrun;
  logic                    w_cnt_en;
  logic                    w_timeout_evt;
  logic                    w_overrun_evt;

  assign w_cnt_inc     = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_overrun_evt = bus.start_i && (r_state != IDLE);

  // The busy cycle that ends WAIT_BUSY is counted too, so cycles_o equals
  // the full number of cycles the core held busy high.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_en      = 1'b0;
    w_timeout_evt = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start_i) begin
          w_state_next = (bus.delay_i != '0) ? DELAY : LOAD;
        end
      end
      DELAY: begin
        if (r_delay == {{(pDELAY_WIDTH-1){1'b0}}, 1'b1}) begin
          w_state_next = LOAD;
        end
      end
      LOAD: w_state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.core_busy_i) begin
          w_cnt_en     = 1'b1;
          w_state_next = RUN;
        end else if (r_wait == cWAIT_LAST) begin
          w_timeout_evt = 1'b1;
          w_state_next  = IDLE;
        end
      end
      RUN: begin
        if (bus.core_busy_i) begin
          w_cnt_en = 1'b1;
          if (w_cnt_inc >= cRUN_MAX) begin
            w_timeout_evt = 1'b1;
            w_state_next  = IDLE;
          end
        end else begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_delay   <= '0;
      r_wait    <= '0;
      r_cnt     <= '0;
      r_cycles  <= '0;
      r_trigger <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_trigger <= (w_state_next inside {LOAD, WAIT_BUSY, RUN});

      if (r_state == IDLE && bus.start_i) begin
        r_delay <= bus.delay_i;
      end else if (r_state == DELAY) begin
        r_delay <= r_delay - 1'b1;
      end

      if (r_state == WAIT_BUSY) begin
        r_wait <= r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end

      if (w_state_next == LOAD) begin
        r_cnt <= '0;
      end else if (w_cnt_en) begin
        r_cnt <= w_cnt_inc;
      end

      if (w_state_next == DONE) begin
        r_cycles <= r_cnt;
      end

      // A new error event wins over a simultaneous clear.
      if (w_timeout_evt) begin
        r_timeout <= 1'b1;
      end else if (bus.clear_err_i) begin
        r_timeout <= 1'b0;
      end

      if (w_overrun_evt) begin
        r_overrun <= 1'b1;
      end else if (bus.clear_err_i) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.core_load_o = (r_state == LOAD);
  assign bus.done_o      = (r_state == DONE);
  assign bus.busy_o      = (r_state != IDLE);
  assign bus.trigger_o   = r_trigger;
  assign bus.cycles_o    = r_cycles;
  assign bus.timeout_o   = r_timeout;
  assign bus.overrun_o   = r_overrun;
endmodule

// File: doc/aes_trigger_ctrl.md
AES_TRIGGER_CTRL -- requirements
Module: aes_trigger_ctrl

Interface
REQ-001 Parameters SHALL be:
- pDELAY_WIDTH, default 16, width of the programmable start-to-load delay.
- pCNT_WIDTH, default 16, width of the busy-cycle counter.
- pWAIT_MAX, default 8, maximum cycles allowed for the core to raise busy after load.
- pRUN_MAX, default 4096, maximum busy cycles allowed before a timeout is declared.
REQ-002 Ports SHALL be:
- clk  in  1  crypto clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle start pulse from the register block.
- delay_i  in  pDELAY_WIDTH  start-to-load delay in cycles, sampled with start_i.
- clear_err_i  in  1  clears the sticky error flags.
- core_busy_i  in  1  busy flag from the AES core.
- core_load_o  out  1  one-cycle load pulse to the AES core.
- trigger_o  out  1  scope trigger output.
- busy_o  out  1  high whenever the block is not IDLE.
- done_o  out  1  one-cycle completion pulse.
- cycles_o  out  pCNT_WIDTH  busy-cycle count of the last completed operation.
- timeout_o  out  1  sticky timeout flag.
- overrun_o  out  1  sticky flag for a start_i received while not IDLE.
REQ-003 The clock SHALL be clk and the reset SHALL be reset; reset is synchronous and active-high, and there is one clock domain.

Function
REQ-004 The FSM SHALL have the states IDLE, DELAY, LOAD, WAIT_BUSY, RUN and DONE.
REQ-005 In IDLE, start_i=1 SHALL latch delay_i and move to DELAY if delay_i>0, otherwise to LOAD.
REQ-006 DELAY SHALL last exactly delay_i cycles, then go to LOAD; core_load_o SHALL therefore be asserted in cycle N+1+D for a start in cycle N.
REQ-007 LOAD SHALL last exactly one cycle with core_load_o=1, then go to WAIT_BUSY.
REQ-008 WAIT_BUSY SHALL go to RUN when core_busy_i=1.
REQ-009 If core_busy_i=1 is not seen within pWAIT_MAX cycles in WAIT_BUSY, the block SHALL set timeout_o and return to IDLE without pulsing done_o.
REQ-010 RUN SHALL increment an internal counter each cycle core_busy_i=1, saturating at all-ones; the counter SHALL be cleared on entry to LOAD.
REQ-011 RUN SHALL go to DONE on the first cycle with core_busy_i=0.
REQ-012 If the counter reaches pRUN_MAX in RUN, the block SHALL set timeout_o and return to IDLE without pulsing done_o.
REQ-013 DONE SHALL last exactly one cycle with done_o=1 and cycles_o updated to the counter value in that same cycle, then go to IDLE.
REQ-014 trigger_o SHALL be 1 exactly in LOAD, WAIT_BUSY and RUN, as a registered state decode with no glitches.
REQ-015 busy_o SHALL be 1 in every state except IDLE.
REQ-016 start_i while not IDLE SHALL be ignored, set overrun_o, and leave the current operation unaffected.
REQ-017 A start_i in the DONE cycle SHALL count as an overrun.
REQ-018 start_i in the first IDLE cycle after DONE or after a timeout SHALL be accepted.
REQ-019 clear_err_i=1 SHALL clear timeout_o and overrun_o on the next edge.
REQ-020 If clear_err_i and a new error event occur in the same cycle, the set SHALL take priority.
REQ-021 cycles_o SHALL hold its value across timeouts and idle periods, and SHALL change only in DONE.

Reset
REQ-022 reset SHALL force IDLE, abandoning any operation in progress, with no done_o pulse.
REQ-023 During and after reset, the outputs SHALL be: core_load_o=0, trigger_o=0, busy_o=0, done_o=0, cycles_o=0, timeout_o=0, overrun_o=0.
REQ-024 Reset asserted mid-RUN SHALL drop trigger_o to 0 in the cycle after reset is sampled.

Verification
REQ-025 Start with delay_i=0, core busy for 11 cycles after the load -> core_load_o in cycle N+1; trigger_o high for 1+1+11 cycles (load, wait, run); done_o one cycle; cycles_o=11.
REQ-026 Start with delay_i=5 -> core_load_o in cycle N+6; trigger_o=0 during the 5 delay cycles; busy_o=1 throughout.
REQ-027 Core never raises busy -> timeout_o=1 after pWAIT_MAX=8 wait cycles; no done_o; next start_i accepted normally.
REQ-028 start_i pulsed during RUN and again in the DONE cycle -> overrun_o=1, exactly one done_o, cycles_o correct; clear_err_i -> overrun_o=0.
REQ-029 Core held busy with pRUN_MAX=4096 -> timeout_o=1 after 4096 counted cycles; cycles_o keeps its prior value.
REQ-030 Reset asserted mid-RUN -> all outputs return to their reset values on the next edge; a fresh start afterwards completes with the correct cycles_o.
